mat_disp_arbiter: RTL and testbench

- Shares the 8x8 bicolour LED matrix scanner between two independent content producers (req0, req1).
- Grants ownership round-robin and enforces a minimum hold time measured in whole frames.
- Presents the owner's 64-bit frame and colour to the scanner, changing them only on frame boundaries so no frame ever tears.
- Sits between the producers and the matrix scan driver; frame_tick comes from the scan driver's row sequencer.

---
 rtl/mat_disp_arbiter_if.sv | 26 ++
 rtl/mat_disp_arbiter.sv | 117 +++++++++++
 tb/tb_mat_disp_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mat_disp_arbiter_if.sv
// Bundle between the two content producers, the arbiter and the matrix scan driver.
// Signal suffixes are named from the arbiter's side of the link.
interface mat_disp_arbiter_if;
  logic        frame_tick_i;
  logic        req0_i;
  logic [63:0] char0_i;
  logic        color0_i;
  logic        req1_i;
  logic [63:0] char1_i;
  logic        color1_i;
  logic [1:0]  gnt_o;
  logic [63:0] char_o;
  logic        color_o;
  logic        blank_o;
  logic [7:0]  frames_o;

  modport slave (
    input  frame_tick_i, req0_i, char0_i, color0_i, req1_i, char1_i, color1_i,
    output gnt_o, char_o, color_o, blank_o, frames_o
  );

  modport master (
    output frame_tick_i, req0_i, char0_i, color0_i, req1_i, char1_i, color1_i,
    input  gnt_o, char_o, color_o, blank_o, frames_o
  );
endinterface

// File: rtl/mat_disp_arbiter.sv
// Round-robin owner of the LED matrix scanner with a frame-counted minimum hold.
// All ownership and content changes land on frame_tick edges, so frames never tear.
module mat_disp_arbiter #(
  parameter int HOLD_FRAMES = 16
) (
  input logic               clk,
  input logic               rst,
  mat_disp_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t      state_q;
  logic [1:0]  gnt_q;
  logic [63:0] char_q;
  logic        color_q;
  logic        blank_q;
  logic [7:0]  frames_q;
  logic        last_q;

  logic        owner_s;
  logic        own_req_s;
  logic        oth_req_s;
  logic        hold_done_s;
  logic        grant_s;
  logic        grant_idx_s;
  logic        reload_s;
  logic        clear_s;
  logic [7:0]  frames_inc_s;

  assign owner_s      = gnt_q[1];
  assign own_req_s    = owner_s ? bus.req1_i : bus.req0_i;
  assign oth_req_s    = owner_s ? bus.req0_i : bus.req1_i;
  // Compare against the unsaturated count so HOLD_FRAMES=255 still releases.
  assign hold_done_s  = ({1'b0, frames_q} + 9'd1) >= 9'(HOLD_FRAMES);
  assign frames_inc_s = (frames_q == 8'd255) ? 8'd255 : frames_q + 8'd1;

  // Decide what the next frame_tick edge does: grant/switch, reload, blank or hold.
  always_comb begin
    grant_s     = 1'b0;
    grant_idx_s = 1'b0;
    reload_s    = 1'b0;
    clear_s     = 1'b0;
    if (bus.frame_tick_i) begin
      case (state_q)
        IDLE: begin
          if (bus.req0_i && bus.req1_i) begin
            grant_s     = 1'b1;
            grant_idx_s = ~last_q;
          end else if (bus.req0_i) begin
            grant_s     = 1'b1;
            grant_idx_s = 1'b0;
          end else if (bus.req1_i) begin
            grant_s     = 1'b1;
            grant_idx_s = 1'b1;
          end else begin
            clear_s = 1'b1;
          end
        end
        OWN: begin
          if (own_req_s && !(oth_req_s && hold_done_s)) begin
            reload_s = 1'b1;
          end else if (oth_req_s) begin
            grant_s     = 1'b1;
            grant_idx_s = ~owner_s;
          end else begin
            clear_s = 1'b1;
          end
        end
        default: begin
          clear_s = 1'b1;
        end
      endcase
    end else begin
      grant_s = 1'b0;
    end
  end

  // State and registered scanner outputs; reset is immediate and drops the hold count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      char_q   <= 64'd0;
      color_q  <= 1'b0;
      blank_q  <= 1'b1;
      frames_q <= 8'd0;
      last_q   <= 1'b1;
    end else if (grant_s) begin
      state_q  <= OWN;
      gnt_q    <= grant_idx_s ? 2'b10 : 2'b01;
      char_q   <= grant_idx_s ? bus.char1_i : bus.char0_i;
      color_q  <= grant_idx_s ? bus.color1_i : bus.color0_i;
      blank_q  <= 1'b0;
      frames_q <= 8'd0;
      last_q   <= grant_idx_s;
    end else if (reload_s) begin
      char_q   <= owner_s ? bus.char1_i : bus.char0_i;
      color_q  <= owner_s ? bus.color1_i : bus.color0_i;
      frames_q <= frames_inc_s;
    end else if (clear_s) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      char_q   <= 64'd0;
      color_q  <= 1'b0;
      blank_q  <= 1'b1;
      frames_q <= 8'd0;
    end
  end

  assign bus.gnt_o    = gnt_q;
  assign bus.char_o   = char_q;
  assign bus.color_o  = color_q;
  assign bus.blank_o  = blank_q;
  assign bus.frames_o = frames_q;

endmodule

// File: tb/tb_mat_disp_arbiter.sv
// Directed bench for mat_disp_arbiter with HOLD_FRAMES=4; outputs sampled on the falling edge.
module tb_mat_disp_arbiter;
  localparam logic [63:0] PAT_P = 64'h0102040810204080;
  localparam logic [63:0] PAT_Q = 64'hFF00FF00FF00FF00;
  localparam logic [63:0] PAT_R = 64'h00FF00FF00FF00FF;
  localparam logic [63:0] PAT_A = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0] PAT_B = 64'h5A5A5A5A5A5A5A5A;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  mat_disp_arbiter_if dif ();

  mat_disp_arbiter #(.HOLD_FRAMES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    dif.frame_tick_i = 1'b1;
    @(negedge clk);
    dif.frame_tick_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [1:0] g, input logic [63:0] c,
                           input logic col, input logic b, input logic [7:0] f);
    check({tag, ".gnt"},    {62'd0, dif.gnt_o},    {62'd0, g});
    check({tag, ".char"},   dif.char_o,            c);
    check({tag, ".color"},  {63'd0, dif.color_o},  {63'd0, col});
    check({tag, ".blank"},  {63'd0, dif.blank_o},  {63'd0, b});
    check({tag, ".frames"}, {56'd0, dif.frames_o}, {56'd0, f});
  endtask

  initial begin
    logic [1:0]  exp_g;
    logic [63:0] exp_c;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    dif.frame_tick_i = 1'b0;
    dif.req0_i = 1'b0; dif.char0_i = 64'd0; dif.color0_i = 1'b0;
    dif.req1_i = 1'b0; dif.char1_i = 64'd0; dif.color1_i = 1'b0;
    idle(3);
    check_all("reset", 2'b00, 64'd0, 1'b0, 1'b1, 8'd0);
    rst = 1'b0;
    idle(2);

    // Single requester, request raised in the tick cycle
    dif.req0_i = 1'b1; dif.char0_i = PAT_P; dif.color0_i = 1'b1;
    tick();
    check_all("grant0", 2'b01, PAT_P, 1'b1, 1'b0, 8'd0);

    // Content changes between ticks are held until the next tick
    dif.char0_i = PAT_Q; dif.color0_i = 1'b0;
    idle(3);
    check("hold_char", dif.char_o, PAT_P);
    check("hold_color", {63'd0, dif.color_o}, 64'd1);
    tick();
    check("reload_q", dif.char_o, PAT_Q);
    check("reload_q.color", {63'd0, dif.color_o}, 64'd0);
    check("reload_q.frames", {56'd0, dif.frames_o}, 64'd1);
    dif.char0_i = PAT_R;
    idle(2);
    check("midframe_char", dif.char_o, PAT_Q);
    tick();
    check("reload_r", dif.char_o, PAT_R);
    check("reload_r.frames", {56'd0, dif.frames_o}, 64'd2);

    // Release under hold: no mid-frame blanking, idle at the tick
    dif.req0_i = 1'b0;
    idle(2);
    check("release_wait.gnt", {62'd0, dif.gnt_o}, 64'd1);
    check("release_wait.char", dif.char_o, PAT_R);
    tick();
    check_all("release", 2'b00, 64'd0, 1'b0, 1'b1, 8'd0);
    tick();
    check_all("idle_tick", 2'b00, 64'd0, 1'b0, 1'b1, 8'd0);

    // Contention after owner 0: tie goes to 1, then switch every 4 frames
    dif.char0_i = PAT_A; dif.color0_i = 1'b0;
    dif.char1_i = PAT_B; dif.color1_i = 1'b1;
    dif.req0_i = 1'b1; dif.req1_i = 1'b1;
    tick();
    check_all("tie_rr", 2'b10, PAT_B, 1'b1, 1'b0, 8'd0);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      check($sformatf("between_%0d", k), dif.char_o, ((k - 1) % 8 < 4) ? PAT_B : PAT_A);
      tick();
      exp_g = (k % 8 < 4) ? 2'b10 : 2'b01;
      exp_c = (k % 8 < 4) ? PAT_B : PAT_A;
      check($sformatf("cont_%0d.gnt", k), {62'd0, dif.gnt_o}, {62'd0, exp_g});
      check($sformatf("cont_%0d.char", k), dif.char_o, exp_c);
      check($sformatf("cont_%0d.frames", k), {56'd0, dif.frames_o}, 64'(k % 4));
    end

    // Owner 1 alone for five frames, then asynchronous reset mid-frame
    dif.req0_i = 1'b0;
    repeat (5) tick();
    check("pre_rst.frames", {56'd0, dif.frames_o}, 64'd5);
    check("pre_rst.gnt", {62'd0, dif.gnt_o}, 64'd2);
    #3 rst = 1'b1;
    #1 check_all("async_rst", 2'b00, 64'd0, 1'b0, 1'b1, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    dif.req0_i = 1'b1; dif.req1_i = 1'b1;
    tick();
    check_all("post_rst_tie", 2'b01, PAT_A, 1'b0, 1'b0, 8'd0);
    dif.req0_i = 1'b0;
    tick();
    check_all("drop0_switch", 2'b10, PAT_B, 1'b1, 1'b0, 8'd0);
    dif.req1_i = 1'b0;
    tick();
    check("to_idle.gnt", {62'd0, dif.gnt_o}, 64'd0);
    dif.req0_i = 1'b1; dif.req1_i = 1'b1;
    tick();
    check("tie_after1.gnt", {62'd0, dif.gnt_o}, 64'd1);

    // Frame counter saturates at 255; switch still happens once the other asks
    dif.req0_i = 1'b0;
    tick();
    check("sat_start.gnt", {62'd0, dif.gnt_o}, 64'd2);
    repeat (260) tick();
    check("sat.frames", {56'd0, dif.frames_o}, 64'd255);
    check("sat.gnt", {62'd0, dif.gnt_o}, 64'd2);
    dif.req0_i = 1'b1;
    tick();
    check_all("sat_switch", 2'b01, PAT_A, 1'b0, 1'b0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
